// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between NUM_REQ
// simple register-access requesters. One transaction is in flight at a time;
// each granted request becomes a full AW+W+B write or AR+R read, and the
// response is returned to the requester that issued it.
module axil_req_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,

    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic [1:0]                      rsp_resp,

    output logic [ADDR_WIDTH-1:0]           M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [DATA_WIDTH-1:0]           M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]         M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [ADDR_WIDTH-1:0]           M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [DATA_WIDTH-1:0]           M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]      wstrb_q, wstrb_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]             resp_q, resp_d;

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       cand;

    // Round-robin search: first pending requester after the last grant.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((32'(last_grant_q) + off) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state logic and handshake outputs of the transaction FSM.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        rdata_d       = rdata_q;
        resp_d        = resp_q;
        req_ready     = '0;
        rsp_valid     = '0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    grant_d      = win_idx;
                    last_grant_d = win_idx;
                    addr_d       = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d      = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    wstrb_d      = req_wstrb[win_idx*STRB_W +: STRB_W];
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    state_d      = req_write[win_idx] ? WR : RD_ADDR;
                end
            end
            WR: begin
                // AW and W complete independently; leave once both have.
                M_AXI_AWVALID = !aw_done_q;
                M_AXI_WVALID  = !w_done_q;
                if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done_d = 1'b1;
                if (M_AXI_WVALID && M_AXI_WREADY)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)          state_d   = WR_RESP;
            end
            WR_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    state_d = DONE;
                end
            end
            RD_ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_d = RD_DATA;
            end
            RD_DATA: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid[grant_q] = 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
        end
    end

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed bench for axil_req_arbiter with a small 4-register AXI4-Lite slave.
module tb_axil_req_arbiter;

    localparam int NR = 2;
    localparam int AW = 4;
    localparam int DW = 32;

    logic              ACLK;
    logic              ARESETN;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*DW/8-1:0] req_wstrb;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [AW-1:0]     M_AXI_AWADDR;
    logic [2:0]        M_AXI_AWPROT;
    logic              M_AXI_AWVALID;
    logic              M_AXI_AWREADY;
    logic [DW-1:0]     M_AXI_WDATA;
    logic [DW/8-1:0]   M_AXI_WSTRB;
    logic              M_AXI_WVALID;
    logic              M_AXI_WREADY;
    logic [1:0]        M_AXI_BRESP;
    logic              M_AXI_BVALID;
    logic              M_AXI_BREADY;
    logic [AW-1:0]     M_AXI_ARADDR;
    logic [2:0]        M_AXI_ARPROT;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [DW-1:0]     M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    // slave knobs
    logic s_awready, s_wready, s_arready, s_err_en, s_bhold;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_rdy = 0;

    axil_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    // ---------------- simple AXI4-Lite slave ----------------
    logic [31:0] mem [4];
    logic        s_aw_got, s_w_got, s_bvalid, s_rvalid;
    logic [3:0]  s_awaddr;
    logic [31:0] s_wdata, s_rdata;
    logic [1:0]  s_rresp;
    logic        aw_hs_s, w_hs_s, wr_now;
    logic [3:0]  aw_a;
    logic [31:0] w_d;

    always_comb begin
        aw_hs_s = M_AXI_AWVALID && M_AXI_AWREADY;
        w_hs_s  = M_AXI_WVALID && M_AXI_WREADY;
        aw_a    = aw_hs_s ? M_AXI_AWADDR : s_awaddr;
        w_d     = w_hs_s ? M_AXI_WDATA : s_wdata;
        wr_now  = (s_aw_got || aw_hs_s) && (s_w_got || w_hs_s);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
            s_awaddr <= '0; s_wdata <= '0; s_rdata <= '0; s_rresp <= '0;
        end else begin
            if (aw_hs_s) begin s_aw_got <= 1'b1; s_awaddr <= M_AXI_AWADDR; end
            if (w_hs_s)  begin s_w_got  <= 1'b1; s_wdata  <= M_AXI_WDATA;  end
            if (wr_now) begin
                s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bvalid <= 1'b1;
            end else if (M_AXI_BVALID && M_AXI_BREADY) begin
                s_bvalid <= 1'b0;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                s_rvalid <= 1'b1;
                s_rdata  <= mem[M_AXI_ARADDR[3:2]];
                s_rresp  <= (s_err_en && M_AXI_ARADDR == 4'hC) ? 2'b10 : 2'b00;
            end else if (M_AXI_RVALID && M_AXI_RREADY) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (wr_now) mem[aw_a[3:2]] <= w_d;
    end

    assign M_AXI_AWREADY = s_awready;
    assign M_AXI_WREADY  = s_wready;
    assign M_AXI_ARREADY = s_arready;
    assign M_AXI_BVALID  = s_bvalid && !s_bhold;
    assign M_AXI_BRESP   = 2'b00;
    assign M_AXI_RVALID  = s_rvalid;
    assign M_AXI_RDATA   = s_rdata;
    assign M_AXI_RRESP   = s_rresp;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic wr, input logic [3:0] a, input logic [31:0] d);
        req_write[r]           = wr;
        req_addr[r*AW +: AW]   = a;
        req_wdata[r*DW +: DW]  = d;
        req_wstrb[r*4 +: 4]    = 4'hF;
        req_valid[r]           = 1'b1;
    endtask

    task automatic wait_ready(input int r, input string tag);
        int n;
        n = 0;
        @(negedge ACLK);
        while (req_ready[r] !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check(tag, 32'(req_ready[r]), 32'd1);
        t_rdy = cyc;
    endtask

    task automatic issue(input int r, input logic wr, input logic [3:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic [1:0] eresp, input string tag);
        int n;
        @(posedge ACLK); #1;
        set_req(r, wr, a, d);
        wait_ready(r, {tag, "_ready"});
        @(posedge ACLK); #1;
        req_valid[r] = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (rsp_valid[r] !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check({tag, "_lat"}, 32'(cyc - t_rdy), 32'd3);
        check({tag, "_rspv"}, 32'(rsp_valid), 32'd1 << r);
        if (!wr) check({tag, "_rdata"}, rsp_rdata, er);
        check({tag, "_resp"}, 32'(rsp_resp), 32'(eresp));
        @(negedge ACLK);
        check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
        if (!wr) check({tag, "_hold"}, rsp_rdata, er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0]  g  [4];
        int          gc [4];
        logic [1:0]  exp_g [4];
        int          k, n, t0;

        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        g     = '{2'b00, 2'b00, 2'b00, 2'b00};
        gc    = '{0, 0, 0, 0};
        ARESETN   = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1; s_err_en = 1'b0; s_bhold = 1'b0;

        // reset state
        repeat (2) @(negedge ACLK);
        check("rst_ready",  32'(req_ready), 32'd0);
        check("rst_rspv",   32'(rsp_valid), 32'd0);
        check("rst_axivr",  32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
        check("rst_rdata",  rsp_rdata, 32'd0);
        check("rst_resp",   32'(rsp_resp), 32'd0);
        check("rst_awaddr", 32'(M_AXI_AWADDR), 32'd0);
        check("rst_wdata",  M_AXI_WDATA, 32'd0);
        check("rst_prot",   32'({M_AXI_AWPROT, M_AXI_ARPROT}), 32'd0);
        ARESETN = 1'b1;

        // simultaneous requesters from reset: 0 first, then alternate
        @(posedge ACLK); #1;
        set_req(0, 1'b0, 4'h0, 32'd0);
        set_req(1, 1'b0, 4'h0, 32'd0);
        t0 = cyc;
        k = 0; n = 0;
        while (k < 4 && n < 40) begin
            @(negedge ACLK);
            n++;
            if (req_ready != '0) begin
                g[k]  = req_ready;
                gc[k] = cyc;
                k++;
            end
        end
        @(posedge ACLK); #1;
        req_valid = '0;
        check("t2_count", 32'(k), 32'd4);
        check("t2_first_same_cycle", 32'(gc[0] - t0), 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("t2_grant%0d", i), 32'(g[i]), 32'(exp_g[i]));
        for (int i = 1; i < 4; i++) check($sformatf("t2_gap%0d", i), 32'(gc[i] - gc[i-1]), 32'd4);
        repeat (5) @(negedge ACLK);

        // requester 0 writes four registers and reads them back
        for (int i = 0; i < 4; i++)
            issue(0, 1'b1, 4'(i*4), 32'(i+1), 32'd0, 2'b00, $sformatf("t1_wr%0d", i));
        for (int i = 0; i < 4; i++)
            issue(0, 1'b0, 4'(i*4), 32'd0, 32'(i+1), 2'b00, $sformatf("t1_rd%0d", i));

        // error response passes through, next request still served
        s_err_en = 1'b1;
        issue(1, 1'b0, 4'hC, 32'd0, 32'd4, 2'b10, "t4_err");
        issue(0, 1'b0, 4'h0, 32'd0, 32'd1, 2'b00, "t4_next");
        s_err_en = 1'b0;

        // AWREADY delayed 3 cycles, WREADY immediate
        s_awready = 1'b0;
        @(posedge ACLK); #1;
        set_req(0, 1'b1, 4'h4, 32'hA5A5_0004);
        wait_ready(0, "t3_ready");
        @(posedge ACLK); #1;
        req_valid[0] = 1'b0;
        @(negedge ACLK);
        check("t3_c1_aw",    32'(M_AXI_AWVALID), 32'd1);
        check("t3_c1_w",     32'(M_AXI_WVALID), 32'd1);
        check("t3_c1_wdata", M_AXI_WDATA, 32'hA5A5_0004);
        @(negedge ACLK);
        check("t3_c2_aw",    32'(M_AXI_AWVALID), 32'd1);
        check("t3_c2_w",     32'(M_AXI_WVALID), 32'd0);
        check("t3_c2_bready", 32'(M_AXI_BREADY), 32'd0);
        @(negedge ACLK);
        check("t3_c3_aw",    32'(M_AXI_AWVALID), 32'd1);
        check("t3_c3_bready", 32'(M_AXI_BREADY), 32'd0);
        @(posedge ACLK); #1;
        s_awready = 1'b1;
        @(negedge ACLK);
        check("t3_c4_aw",    32'(M_AXI_AWVALID), 32'd1);
        check("t3_c4_awaddr", 32'(M_AXI_AWADDR), 32'h4);
        check("t3_c4_bready", 32'(M_AXI_BREADY), 32'd0);
        @(negedge ACLK);
        check("t3_c5_aw",    32'(M_AXI_AWVALID), 32'd0);
        check("t3_c5_bready", 32'(M_AXI_BREADY), 32'd1);
        check("t3_c5_rspv",  32'(rsp_valid), 32'd0);
        @(negedge ACLK);
        check("t3_c6_rspv",  32'(rsp_valid), 32'd1);
        check("t3_c6_resp",  32'(rsp_resp), 32'd0);
        @(negedge ACLK);
        check("t3_c7_rspv",  32'(rsp_valid), 32'd0);

        // reset during WR_RESP
        s_bhold = 1'b1;
        @(posedge ACLK); #1;
        set_req(0, 1'b1, 4'h8, 32'h0000_0BAD);
        wait_ready(0, "t5_ready");
        @(posedge ACLK); #1;
        req_valid[0] = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        check("t5_in_wr_resp", 32'(M_AXI_BREADY), 32'd1);
        #1 ARESETN = 1'b0;
        #1;
        check("t5_rst_axivr", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
        check("t5_rst_rspv",  32'(rsp_valid), 32'd0);
        check("t5_rst_rdata", rsp_rdata, 32'd0);
        check("t5_rst_awaddr", 32'(M_AXI_AWADDR), 32'd0);
        check("t5_rst_wdata", M_AXI_WDATA, 32'd0);
        s_bhold = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check($sformatf("t5_no_rsp%0d", i), 32'(rsp_valid), 32'd0);
        end
        @(posedge ACLK); #1;
        set_req(0, 1'b0, 4'h0, 32'd0);
        set_req(1, 1'b0, 4'h4, 32'd0);
        @(negedge ACLK);
        check("t5_first_grant", 32'(req_ready), 32'd1);
        @(posedge ACLK); #1;
        req_valid = '0;
        repeat (5) @(negedge ACLK);

        // requester 1 arrives while requester 0's read is in RD_DATA
        @(posedge ACLK); #1;
        set_req(0, 1'b0, 4'hC, 32'd0);
        wait_ready(0, "t6_ready");
        @(posedge ACLK); #1;
        req_valid[0] = 1'b0;
        @(negedge ACLK);
        check("t6_arvalid", 32'(M_AXI_ARVALID), 32'd1);
        @(posedge ACLK); #1;
        set_req(1, 1'b0, 4'h8, 32'd0);
        @(negedge ACLK);
        check("t6_rready",   32'(M_AXI_RREADY), 32'd1);
        check("t6_rd_ready", 32'(req_ready), 32'd0);
        @(negedge ACLK);
        check("t6_done_rspv",  32'(rsp_valid), 32'd1);
        check("t6_done_ready", 32'(req_ready), 32'd0);
        check("t6_done_rdata", rsp_rdata, 32'd4);
        @(negedge ACLK);
        check("t6_idle_ready", 32'(req_ready), 32'd2);
        @(posedge ACLK); #1;
        req_valid = '0;
        repeat (3) @(negedge ACLK);
        check("t6_r1_rspv",  32'(rsp_valid), 32'd2);
        check("t6_r1_rdata", rsp_rdata, 32'h0000_0BAD);
        check("t6_r1_resp",  32'(rsp_resp), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
